gray_counter_ctrl: RTL and testbench
====================================

GRAY_COUNTER_CTRL -- requirements
Module: gray_counter_ctrl

Interface
REQ-001 SHALL provide parameter DIV, default 4, meaning prescaler divisor: clk cycles per counter advance in RUN; legal range 1..2^24.
REQ-002 SHALL provide port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port start  input  1  request continuous counting, sampled every edge.
REQ-005 SHALL provide port stop  input  1  request pause, or return to idle from PAUSE.
REQ-006 SHALL provide port step  input  1  request exactly one counter advance.
REQ-007 SHALL provide port dir  input  1  direction request: 0 = up, 1 = down.
REQ-008 SHALL provide port cnt_en  output  1  one-cycle advance enable to the gray counter datapath.
REQ-009 SHALL provide port cnt_dir  output  1  direction to the gray counter datapath.
REQ-010 SHALL provide port busy  output  1  high when state is not IDLE.
REQ-011 SHALL provide port state  output  2  state code: IDLE=00, RUN=01, PAUSE=10, STEP=11.
REQ-012 SHALL provide port done  output  1  one-cycle auto-stop pulse; constant 0 when the macro is undefined.

Function
REQ-013 FSM SHALL transition as follows. IDLE: start -> RUN; else step -> STEP; else stay.
REQ-014 RUN: stop -> PAUSE; else stay. start and step are ignored.
REQ-015 PAUSE: stop -> IDLE; else start -> RUN; else step -> STEP; else stay.
REQ-016 STEP SHALL last exactly one cycle, then return to the state it was entered from (IDLE or PAUSE), held in a 1-bit return register.
REQ-017 Simultaneous requests SHALL resolve with priority stop > start > step.
REQ-018 Prescaler SHALL be a counter 0..DIV-1 that increments only in RUN and wraps DIV-1 -> 0.
REQ-019 Prescaler SHALL be held in PAUSE and STEP, and cleared to 0 on entry to IDLE and on the IDLE->RUN transition.
REQ-020 cnt_en SHALL equal (state==RUN && prescaler==DIV-1) || state==STEP.
REQ-021 First cnt_en after IDLE->RUN SHALL occur DIV cycles after the edge that enters RUN; with DIV=1, cnt_en SHALL be high every RUN cycle.
REQ-022 cnt_dir SHALL be a register loaded from dir only on an accepted start or step transition, and held otherwise; dir changes during RUN SHALL have no effect.
REQ-023 PAUSE->RUN SHALL resume from the held prescaler value, so the next cnt_en occurs DIV-p cycles after resuming (p = held value).
REQ-024 An 8-bit-free design SHALL be used: prescaler width = ceil(log2(DIV)), minimum 1 bit.

Reset
REQ-025 On rst high at a clk edge: state=IDLE, prescaler=0, cnt_dir=0, return register=IDLE, tick counter=0.
REQ-026 During reset, outputs SHALL be cnt_en=0, busy=0, done=0, state=00.
REQ-027 rst SHALL override all requests in the same cycle; a pending STEP SHALL be abandoned with no cnt_en.

Configuration
REQ-028 Macro GRAY_CTRL_AUTOSTOP_EN defined: a 3-bit tick counter SHALL count cnt_en pulses issued in RUN. It clears on IDLE->RUN, holds in PAUSE, and is not counted in STEP.
REQ-029 With the macro defined, on the edge after the 8th RUN pulse (one full gray cycle), FSM SHALL go to IDLE and done SHALL pulse for one cycle. stop in that same cycle SHALL take priority and go to PAUSE with no done.
REQ-030 Macro undefined: no tick counter, RUN SHALL continue until stop, and done SHALL be tied 0.

Verification
REQ-031 DIV=4; rst 2 cycles, then start pulse, dir=0 -> state=01 next cycle; cnt_en high once every 4 cycles, first on the 4th RUN cycle; cnt_dir=0.
REQ-032 In IDLE, step pulse with dir=1 -> state=11 for one cycle, cnt_en=1, cnt_dir=1, then state=00 with no further cnt_en.
REQ-033 RUN with prescaler=2, stop pulse -> PAUSE; start 10 cycles later -> next cnt_en 2 cycles after re-entry. A second stop from PAUSE -> IDLE with prescaler=0.
REQ-034 start+stop+step all high in PAUSE -> IDLE. start+step in IDLE -> RUN. rst asserted in STEP -> IDLE with cnt_en=0 that cycle.
REQ-035 GRAY_CTRL_AUTOSTOP_EN, DIV=1: start -> exactly 8 cnt_en pulses, then done=1 for one cycle and state=00. Without the macro, >8 pulses and done stays 0.

Source files
------------

// File: rtl/gray_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter_ctrl
// Description : Control FSM and prescaler for a gray-code counter datapath.
//               States IDLE/RUN/PAUSE/STEP. In RUN a prescaler issues one
//               cnt_en pulse every DIV clocks; STEP issues exactly one pulse
//               and returns to the state it was entered from.
//               Request priority: stop > start > step.
// Parameters  : DIV   - clk cycles per counter advance in RUN (1..2^24)
// Ports       : clk     - system clock, rising edge
//               rst     - synchronous active-high reset
//               start   - request continuous counting
//               stop    - request pause / return to idle from PAUSE
//               step    - request a single counter advance
//               dir     - direction request (0 = up, 1 = down)
//               cnt_en  - one-cycle advance enable to the datapath
//               cnt_dir - registered direction to the datapath
//               busy    - state is not IDLE
//               state   - IDLE=00, RUN=01, PAUSE=10, STEP=11
//               done    - one-cycle auto-stop pulse
// Option      : GRAY_CTRL_AUTOSTOP_EN - when defined, RUN stops by itself
//               after 8 advances (one full 3-bit gray cycle) and pulses
//               done. When undefined, done is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_counter_ctrl #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       dir,
    output logic       cnt_en,
    output logic       cnt_dir,
    output logic       busy,
    output logic [1:0] state,
    output logic       done
);

    localparam int              c_PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(DIV - 1);

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_RUN   = 2'b01;
    localparam logic [1:0] c_PAUSE = 2'b10;
    localparam logic [1:0] c_STEP  = 2'b11;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_PW-1:0] r_presc;
    logic [c_PW-1:0] w_presc_nxt;
    logic            r_ret;        // 0: STEP returns to IDLE, 1: to PAUSE
    logic            w_ret_nxt;
    logic            r_dir;
    logic            w_dir_nxt;
    logic            w_run_pulse;
    logic            w_autostop;

    assign w_run_pulse = (r_state == c_RUN) && (r_presc == c_PRESC_MAX);

`ifdef GRAY_CTRL_AUTOSTOP_EN
    logic [2:0] r_tick;
    logic       r_done;

    // The 8th RUN pulse ends the run unless stop arrives in the same cycle.
    assign w_autostop = w_run_pulse && (r_tick == 3'd7) && !stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= 3'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_autostop;
            if ((r_state == c_IDLE) && (w_state_nxt == c_RUN)) begin
                r_tick <= 3'd0;
            end else if (w_run_pulse) begin
                r_tick <= r_tick + 3'd1;
            end
        end
    end

    assign done = r_done && !rst;
`else
    assign w_autostop = 1'b0;
    assign done       = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_ret_nxt   = r_ret;
        w_dir_nxt   = r_dir;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_RUN;
                    w_presc_nxt = '0;
                    w_dir_nxt   = dir;
                end else if (step) begin
                    w_state_nxt = c_STEP;
                    w_ret_nxt   = 1'b0;
                    w_dir_nxt   = dir;
                end
            end
            c_RUN: begin
                // The prescaler only advances on edges that stay in RUN, so a
                // stop freezes the value seen in the stop cycle.
                if (stop) begin
                    w_state_nxt = c_PAUSE;
                end else if (w_autostop) begin
                    w_state_nxt = c_IDLE;
                    w_presc_nxt = '0;
                end else if (r_presc == c_PRESC_MAX) begin
                    w_presc_nxt = '0;
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            c_PAUSE: begin
                if (stop) begin
                    w_state_nxt = c_IDLE;
                    w_presc_nxt = '0;
                end else if (start) begin
                    w_state_nxt = c_RUN;
                    w_dir_nxt   = dir;
                end else if (step) begin
                    w_state_nxt = c_STEP;
                    w_ret_nxt   = 1'b1;
                    w_dir_nxt   = dir;
                end
            end
            c_STEP: begin
                if (r_ret) begin
                    w_state_nxt = c_PAUSE;
                end else begin
                    w_state_nxt = c_IDLE;
                    w_presc_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_presc_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_presc <= '0;
            r_ret   <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_ret   <= w_ret_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // Outputs are masked while rst is high so a STEP caught by reset never
    // produces an advance.
    assign state   = rst ? c_IDLE : r_state;
    assign cnt_en  = !rst && (w_run_pulse || (r_state == c_STEP));
    assign busy    = !rst && (r_state != c_IDLE);
    assign cnt_dir = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_counter_ctrl
// Description : Self-checking bench for gray_counter_ctrl. One instance with
//               DIV=4 and one with DIV=1. Each scenario task builds a table of
//               stimulus rows and hand-derived expected output vectors
//               {state, cnt_en, cnt_dir, busy, done}; expectations go into a
//               scoreboard queue when a row is driven and are popped and
//               compared at the following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, step = 1'b0, dir = 1'b0;
    logic       cnt_en, cnt_dir, busy, done;
    logic [1:0] state;

    logic       start1 = 1'b0, stop1 = 1'b0, step1 = 1'b0, dir1 = 1'b0;
    logic       cnt_en1, cnt_dir1, busy1, done1;
    logic [1:0] state1;

    logic [5:0] sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    gray_counter_ctrl #(.DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .dir(dir),
        .cnt_en(cnt_en), .cnt_dir(cnt_dir), .busy(busy), .state(state), .done(done)
    );

    gray_counter_ctrl #(.DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop1), .step(step1), .dir(dir1),
        .cnt_en(cnt_en1), .cnt_dir(cnt_dir1), .busy(busy1), .state(state1), .done(done1)
    );

    function automatic logic [5:0] e(input logic [1:0] s, input logic en,
                                     input logic d, input logic b, input logic dn);
        return {s, en, d, b, dn};
    endfunction

    // Rows are {rst, start, stop, step, dir} for the DIV=4 instance.
    task automatic test_reset();
        logic [4:0] st[$];
        logic [5:0] ex[$];
        logic [5:0] got, want;
        st.push_back(5'b10000); ex.push_back(e(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        st.push_back(5'b00000); ex.push_back(e(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            {rst, start, stop, step, dir} = st[i];
            sb_q.push_back(ex[i]);
            @(negedge clk);
            got  = {state, cnt_en, cnt_dir, busy, done};
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_reset row %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_run();
        logic [4:0] st[$];
        logic [5:0] ex[$];
        logic [5:0] got, want;
        st.push_back(5'b01000); ex.push_back(e(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        // RUN cycle k sees prescaler (k-1)%4; dir wiggles are ignored; stop at p=2
        for (int k = 1; k <= 11; k++) begin
            st.push_back({2'b00, (k == 11), 1'b0, (k >= 2 && k <= 6)});
            ex.push_back(e(2'b01, (k == 4 || k == 8), 1'b0, 1'b1, 1'b0));
        end
        foreach (st[i]) begin
            {rst, start, stop, step, dir} = st[i];
            sb_q.push_back(ex[i]);
            @(negedge clk);
            got  = {state, cnt_en, cnt_dir, busy, done};
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_run row %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_pause();
        logic [4:0] st[$];
        logic [5:0] ex[$];
        logic [5:0] got, want;
        for (int k = 0; k < 10; k++) begin
            st.push_back(5'b00000); ex.push_back(e(2'b10, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        st.push_back(5'b00011); ex.push_back(e(2'b10, 1'b0, 1'b0, 1'b1, 1'b0)); // step, dir=1
        st.push_back(5'b00000); ex.push_back(e(2'b11, 1'b1, 1'b1, 1'b1, 1'b0)); // STEP
        st.push_back(5'b01000); ex.push_back(e(2'b10, 1'b0, 1'b1, 1'b1, 1'b0)); // back, start
        st.push_back(5'b00000); ex.push_back(e(2'b01, 1'b0, 1'b0, 1'b1, 1'b0)); // p=2
        st.push_back(5'b00100); ex.push_back(e(2'b01, 1'b1, 1'b0, 1'b1, 1'b0)); // p=3, stop
        st.push_back(5'b00100); ex.push_back(e(2'b10, 1'b0, 1'b0, 1'b1, 1'b0)); // stop -> IDLE
        st.push_back(5'b00000); ex.push_back(e(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            {rst, start, stop, step, dir} = st[i];
            sb_q.push_back(ex[i]);
            @(negedge clk);
            got  = {state, cnt_en, cnt_dir, busy, done};
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_pause row %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_step();
        logic [4:0] st[$];
        logic [5:0] ex[$];
        logic [5:0] got, want;
        st.push_back(5'b00011); ex.push_back(e(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        st.push_back(5'b00000); ex.push_back(e(2'b11, 1'b1, 1'b1, 1'b1, 1'b0));
        st.push_back(5'b00000); ex.push_back(e(2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
        st.push_back(5'b00000); ex.push_back(e(2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
        foreach (st[i]) begin
            {rst, start, stop, step, dir} = st[i];
            sb_q.push_back(ex[i]);
            @(negedge clk);
            got  = {state, cnt_en, cnt_dir, busy, done};
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_step row %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        logic [4:0] st[$];
        logic [5:0] ex[$];
        logic [5:0] got, want;
        st.push_back(5'b01010); ex.push_back(e(2'b00, 1'b0, 1'b1, 1'b0, 1'b0)); // start+step
        st.push_back(5'b01010); ex.push_back(e(2'b01, 1'b0, 1'b0, 1'b1, 1'b0)); // ignored
        st.push_back(5'b01011); ex.push_back(e(2'b01, 1'b0, 1'b0, 1'b1, 1'b0)); // ignored
        st.push_back(5'b00000); ex.push_back(e(2'b01, 1'b0, 1'b0, 1'b1, 1'b0));
        st.push_back(5'b00100); ex.push_back(e(2'b01, 1'b1, 1'b0, 1'b1, 1'b0)); // 4th: pulse
        st.push_back(5'b01110); ex.push_back(e(2'b10, 1'b0, 1'b0, 1'b1, 1'b0)); // all three
        st.push_back(5'b00000); ex.push_back(e(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            {rst, start, stop, step, dir} = st[i];
            sb_q.push_back(ex[i]);
            @(negedge clk);
            got  = {state, cnt_en, cnt_dir, busy, done};
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_priority row %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rst_in_step();
        logic [4:0] st[$];
        logic [5:0] ex[$];
        logic [5:0] got, want;
        st.push_back(5'b00011); ex.push_back(e(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        st.push_back(5'b10000); ex.push_back(e(2'b00, 1'b0, 1'b1, 1'b0, 1'b0)); // STEP masked
        st.push_back(5'b00000); ex.push_back(e(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            {rst, start, stop, step, dir} = st[i];
            sb_q.push_back(ex[i]);
            @(negedge clk);
            got  = {state, cnt_en, cnt_dir, busy, done};
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_rst_in_step row %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    // Rows are {start1, stop1, step1, dir1} for the DIV=1 instance.
    task automatic test_div1_run();
        logic [3:0] st[$];
        logic [5:0] ex[$];
        logic [5:0] got, want;
        st.push_back(4'b1000); ex.push_back(e(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
`ifdef GRAY_CTRL_AUTOSTOP_EN
        for (int k = 0; k < 8; k++) begin
            st.push_back(4'b0000); ex.push_back(e(2'b01, 1'b1, 1'b0, 1'b1, 1'b0));
        end
        st.push_back(4'b0000); ex.push_back(e(2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
        st.push_back(4'b0000); ex.push_back(e(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
`else
        for (int k = 0; k < 12; k++) begin
            st.push_back(4'b0000); ex.push_back(e(2'b01, 1'b1, 1'b0, 1'b1, 1'b0));
        end
        st.push_back(4'b0100); ex.push_back(e(2'b01, 1'b1, 1'b0, 1'b1, 1'b0));
        st.push_back(4'b0100); ex.push_back(e(2'b10, 1'b0, 1'b0, 1'b1, 1'b0));
        st.push_back(4'b0000); ex.push_back(e(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
        foreach (st[i]) begin
            {start1, stop1, step1, dir1} = st[i];
            sb_q.push_back(ex[i]);
            @(negedge clk);
            got  = {state1, cnt_en1, cnt_dir1, busy1, done1};
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_div1_run row %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_run();
        test_pause();
        test_step();
        test_priority();
        test_rst_in_step();
        test_div1_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
